// File: rtl/biu_lite.sv
// biu_lite: bus interface responder for the PRV332SV0 control unit.
// Optional bus watchdog is enabled by defining BIU_TIMEOUT_EN (counter width TO_W).
module biu_lite #(
    parameter int unsigned TO_W = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  opc_biu,
    input  logic [31:0] addr_biu,
    input  logic [31:0] data_st,
    output logic        rdy_biu,
    output logic [31:0] ins,
    output logic [31:0] data_ld,
    output logic        ins_addr_mis,
    output logic        ins_acc_fault,
    output logic        load_addr_mis,
    output logic        load_acc_fault,
    output logic        st_addr_mis,
    output logic        st_acc_fault,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic        bus_ack,
    input  logic        bus_err,
    input  logic [31:0] bus_rdata
);

    localparam logic [2:0]  OPC_NONE  = 3'b000;
    localparam logic [2:0]  OPC_FETCH = 3'b001;
    localparam logic [2:0]  OPC_LB    = 3'b010;
    localparam logic [2:0]  OPC_LH    = 3'b011;
    localparam logic [2:0]  OPC_LW    = 3'b100;
    localparam logic [2:0]  OPC_SB    = 3'b101;
    localparam logic [2:0]  OPC_SH    = 3'b110;
    localparam logic [2:0]  OPC_SW    = 3'b111;
    localparam logic [31:0] NOP_INSN  = 32'h0000_0013;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_WAIT = 2'b01,
        S_DONE = 2'b10
    } state_t;

    state_t      state_q, state_d;
    logic [2:0]  op_q, op_d;
    logic [1:0]  lo_q, lo_d;

    logic        rdy_d, iam_d, iaf_d, lam_d, laf_d, sam_d, saf_d;
    logic        req_d, we_d;
    logic [31:0] addr_d, wdata_d, ins_d, ld_d;
    logic [3:0]  be_d;

    logic        mis_c;
    logic [3:0]  be_c;
    logic [31:0] wdata_c;
    logic [31:0] rd_shift_c;
    logic [31:0] ld_c;
    logic        to_c;

    function automatic logic is_fetch(input logic [2:0] op);
        return op == OPC_FETCH;
    endfunction

    function automatic logic is_load(input logic [2:0] op);
        return (op == OPC_LB) || (op == OPC_LH) || (op == OPC_LW);
    endfunction

    function automatic logic is_store(input logic [2:0] op);
        return (op == OPC_SB) || (op == OPC_SH) || (op == OPC_SW);
    endfunction

    // Decode of the incoming request: alignment, byte enables and lane replication
    always_comb begin
        mis_c   = 1'b0;
        be_c    = 4'b1111;
        wdata_c = 32'h0;
        unique case (opc_biu)
            OPC_FETCH, OPC_LW: mis_c = (addr_biu[1:0] != 2'b00);
            OPC_LH:            mis_c = addr_biu[0];
            OPC_SB: begin
                be_c    = 4'b0001 << addr_biu[1:0];
                wdata_c = {4{data_st[7:0]}};
            end
            OPC_SH: begin
                mis_c   = addr_biu[0];
                be_c    = addr_biu[1] ? 4'b1100 : 4'b0011;
                wdata_c = {2{data_st[15:0]}};
            end
            OPC_SW: begin
                mis_c   = (addr_biu[1:0] != 2'b00);
                wdata_c = data_st;
            end
            default: ;
        endcase
    end

    // Load data: shift the addressed lane down, then zero-extend to the access size
    always_comb begin
        rd_shift_c = bus_rdata >> {lo_q, 3'b000};
        unique case (op_q)
            OPC_LB:  ld_c = {24'h0, rd_shift_c[7:0]};
            OPC_LH:  ld_c = {16'h0, rd_shift_c[15:0]};
            default: ld_c = rd_shift_c;
        endcase
    end

`ifdef BIU_TIMEOUT_EN
    logic [TO_W-1:0] to_cnt_q;
    logic [TO_W-1:0] to_cnt_inc;

    assign to_cnt_inc = to_cnt_q + TO_W'(1);
    assign to_c       = &to_cnt_inc;

    // Counter is held at zero outside WAIT, so it starts from zero on every entry
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            to_cnt_q <= '0;
        end else if (state_q != S_WAIT) begin
            to_cnt_q <= '0;
        end else if (!bus_ack && !bus_err) begin
            to_cnt_q <= to_cnt_inc;
        end
    end
`else
    assign to_c = 1'b0;
    if (TO_W == 0) begin : g_to_w_zero
    end
`endif

    // Next-state and next-output logic
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        lo_d    = lo_q;
        rdy_d   = 1'b0;
        iam_d   = 1'b0;
        iaf_d   = 1'b0;
        lam_d   = 1'b0;
        laf_d   = 1'b0;
        sam_d   = 1'b0;
        saf_d   = 1'b0;
        req_d   = bus_req;
        we_d    = bus_we;
        addr_d  = bus_addr;
        be_d    = bus_be;
        wdata_d = bus_wdata;
        ins_d   = ins;
        ld_d    = data_ld;

        unique case (state_q)
            S_IDLE: begin
                if (opc_biu != OPC_NONE) begin
                    op_d = opc_biu;
                    lo_d = addr_biu[1:0];
                    if (mis_c) begin
                        state_d = S_DONE;
                        iam_d   = is_fetch(opc_biu);
                        lam_d   = is_load(opc_biu);
                        sam_d   = is_store(opc_biu);
                    end else begin
                        state_d = S_WAIT;
                        req_d   = 1'b1;
                        we_d    = is_store(opc_biu);
                        addr_d  = {addr_biu[31:2], 2'b00};
                        be_d    = be_c;
                        wdata_d = wdata_c;
                    end
                end
            end
            S_WAIT: begin
                // err beats ack; either beats the watchdog
                if (bus_err || (!bus_ack && to_c)) begin
                    state_d = S_DONE;
                    req_d   = 1'b0;
                    iaf_d   = is_fetch(op_q);
                    laf_d   = is_load(op_q);
                    saf_d   = is_store(op_q);
                end else if (bus_ack) begin
                    state_d = S_DONE;
                    req_d   = 1'b0;
                    rdy_d   = 1'b1;
                    if (is_fetch(op_q)) begin
                        ins_d = bus_rdata;
                    end
                    if (is_load(op_q)) begin
                        ld_d = ld_c;
                    end
                end
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= S_IDLE;
            op_q           <= OPC_NONE;
            lo_q           <= 2'b00;
            rdy_biu        <= 1'b0;
            ins_addr_mis   <= 1'b0;
            ins_acc_fault  <= 1'b0;
            load_addr_mis  <= 1'b0;
            load_acc_fault <= 1'b0;
            st_addr_mis    <= 1'b0;
            st_acc_fault   <= 1'b0;
            bus_req        <= 1'b0;
            bus_we         <= 1'b0;
            bus_addr       <= 32'h0;
            bus_be         <= 4'h0;
            bus_wdata      <= 32'h0;
            ins            <= NOP_INSN;
            data_ld        <= 32'h0;
        end else begin
            state_q        <= state_d;
            op_q           <= op_d;
            lo_q           <= lo_d;
            rdy_biu        <= rdy_d;
            ins_addr_mis   <= iam_d;
            ins_acc_fault  <= iaf_d;
            load_addr_mis  <= lam_d;
            load_acc_fault <= laf_d;
            st_addr_mis    <= sam_d;
            st_acc_fault   <= saf_d;
            bus_req        <= req_d;
            bus_we         <= we_d;
            bus_addr       <= addr_d;
            bus_be         <= be_d;
            bus_wdata      <= wdata_d;
            ins            <= ins_d;
            data_ld        <= ld_d;
        end
    end

endmodule
